// File: rtl/ctrl_pipeline_pkg.sv
// Shared control-bundle types and forwarding-select encodings for the RV32I
// ID/EX -> EX/MEM -> MEM/WB control path.
package ctrl_pkg;

    localparam int CP_REG_W   = 5;
    localparam int CP_ALUOP_W = 2;

    typedef struct packed {
        logic                  branch;
        logic                  memread;
        logic                  memtoreg;
        logic                  memwrite;
        logic                  alusrc;
        logic                  regwrite;
        logic [CP_ALUOP_W-1:0] aluop;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decoder-side inputs and per-stage control outputs of ctrl_pipeline.
// The slave modport is the pipeline's view; master is the driving side.
interface ctrl_pipeline_if #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
);
    logic               id_valid;
    logic               id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
    logic [ALUOP_W-1:0] id_aluop;
    logic [REG_W-1:0]   id_rs1, id_rs2, id_rd;
    logic               ex_zero;

    logic               stall, flush;
    logic               ex_valid, ex_branch, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite, ex_memtoreg;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [REG_W-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic               mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
    logic [REG_W-1:0]   mem_rd;
    logic               wb_valid, wb_regwrite, wb_memtoreg;
    logic [REG_W-1:0]   wb_rd;
    logic [1:0]         fwd_a, fwd_b;

    modport master (
        output id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
               id_aluop, id_rs1, id_rs2, id_rd, ex_zero,
        input  stall, flush,
               ex_valid, ex_branch, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite, ex_memtoreg,
               ex_aluop, ex_rs1, ex_rs2, ex_rd,
               mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd,
               wb_valid, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite,
               id_aluop, id_rs1, id_rs2, id_rd, ex_zero,
        output stall, flush,
               ex_valid, ex_branch, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite, ex_memtoreg,
               ex_aluop, ex_rs1, ex_rs2, ex_rd,
               mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd,
               wb_valid, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_pipeline_hazard.sv
// Combinational hazard/forwarding logic: load-use stall, taken-branch flush,
// and EX operand selects. Zero latency; flush overrides stall.
module hazard_fwd_unit
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_branch,
    input  logic             i_ex_memread,
    input  logic             i_ex_zero,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_ex_rs1,
    input  logic [REG_W-1:0] i_ex_rs2,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_mem_valid,
    input  logic             i_mem_regwrite,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_wb_valid,
    input  logic             i_wb_regwrite,
    input  logic [REG_W-1:0] i_wb_rd,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_load_use,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b
);

    logic w_mem_wr, w_wb_wr;

    // x0 is hardwired zero, so a write to it is never a forwarding source.
    assign w_mem_wr = i_mem_valid & i_mem_regwrite & (i_mem_rd != '0);
    assign w_wb_wr  = i_wb_valid & i_wb_regwrite & (i_wb_rd != '0);

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                           input logic mem_wr, input logic [REG_W-1:0] mem_rd,
                                           input logic wb_wr,  input logic [REG_W-1:0] wb_rd);
        if (mem_wr && mem_rd == rs)
            return FWD_MEM;
        else if (wb_wr && wb_rd == rs)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        o_flush    = i_ex_valid & i_ex_branch & i_ex_zero;
        o_load_use = i_ex_valid & i_ex_memread & (i_ex_rd != '0) & i_id_valid &
                     ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));
        o_stall    = o_load_use & ~o_flush;
        o_fwd_a    = fwd_sel(i_ex_rs1, w_mem_wr, i_mem_rd, w_wb_wr, i_wb_rd);
        o_fwd_b    = fwd_sel(i_ex_rs2, w_mem_wr, i_mem_rd, w_wb_wr, i_wb_rd);
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoder control through ID/EX, EX/MEM, MEM/WB (EX +1, MEM +2, WB +3 cycles).
// ID/EX bubbles on load-use or taken branch; EX/MEM and MEM/WB always advance.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_W   = CP_REG_W,
    parameter int ALUOP_W = CP_ALUOP_W
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);

    ctrl_bundle_t     w_id_ctrl;
    logic             w_stall, w_flush, w_load_use, w_bubble;
    logic [1:0]       w_fwd_a, w_fwd_b;

    logic             r_ex_valid;
    ctrl_bundle_t     r_ex_ctrl;
    logic [REG_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;

    logic             r_mem_valid, r_mem_memread, r_mem_memwrite, r_mem_regwrite, r_mem_memtoreg;
    logic [REG_W-1:0] r_mem_rd;

    logic             r_wb_valid, r_wb_regwrite, r_wb_memtoreg;
    logic [REG_W-1:0] r_wb_rd;

    // memtoreg is a don't-care from the decoder when nothing is written back.
    always_comb begin
        w_id_ctrl          = CTRL_BUBBLE;
        w_id_ctrl.branch   = bus.id_branch;
        w_id_ctrl.memread  = bus.id_memread;
        w_id_ctrl.memtoreg = bus.id_memtoreg & bus.id_regwrite;
        w_id_ctrl.memwrite = bus.id_memwrite;
        w_id_ctrl.alusrc   = bus.id_alusrc;
        w_id_ctrl.regwrite = bus.id_regwrite;
        w_id_ctrl.aluop    = CP_ALUOP_W'(bus.id_aluop);
    end

    assign w_bubble = w_flush | w_load_use | ~bus.id_valid;

    hazard_fwd_unit #(.REG_W(REG_W)) u_hazard (
        .i_ex_valid     (r_ex_valid),
        .i_ex_branch    (r_ex_ctrl.branch),
        .i_ex_memread   (r_ex_ctrl.memread),
        .i_ex_zero      (bus.ex_zero),
        .i_ex_rd        (r_ex_rd),
        .i_ex_rs1       (r_ex_rs1),
        .i_ex_rs2       (r_ex_rs2),
        .i_id_valid     (bus.id_valid),
        .i_id_rs1       (bus.id_rs1),
        .i_id_rs2       (bus.id_rs2),
        .i_mem_valid    (r_mem_valid),
        .i_mem_regwrite (r_mem_regwrite),
        .i_mem_rd       (r_mem_rd),
        .i_wb_valid     (r_wb_valid),
        .i_wb_regwrite  (r_wb_regwrite),
        .i_wb_rd        (r_wb_rd),
        .o_stall        (w_stall),
        .o_flush        (w_flush),
        .o_load_use     (w_load_use),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b)
    );

    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= CTRL_BUBBLE;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_rd    <= '0;
        end else begin
            r_ex_valid <= 1'b1;
            r_ex_ctrl  <= w_id_ctrl;
            r_ex_rs1   <= bus.id_rs1;
            r_ex_rs2   <= bus.id_rs2;
            r_ex_rd    <= bus.id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_valid    <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_rd       <= '0;
        end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_memread  <= r_ex_ctrl.memread;
            r_mem_memwrite <= r_ex_ctrl.memwrite;
            r_mem_regwrite <= r_ex_ctrl.regwrite;
            r_mem_memtoreg <= r_ex_ctrl.memtoreg;
            r_mem_rd       <= r_ex_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_rd       <= '0;
        end else begin
            r_wb_valid    <= r_mem_valid;
            r_wb_regwrite <= r_mem_regwrite;
            r_wb_memtoreg <= r_mem_memtoreg;
            r_wb_rd       <= r_mem_rd;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.fwd_a        = w_fwd_a;
    assign bus.fwd_b        = w_fwd_b;

    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_branch    = r_ex_ctrl.branch;
    assign bus.ex_memread   = r_ex_ctrl.memread;
    assign bus.ex_memwrite  = r_ex_ctrl.memwrite;
    assign bus.ex_alusrc    = r_ex_ctrl.alusrc;
    assign bus.ex_regwrite  = r_ex_ctrl.regwrite;
    assign bus.ex_memtoreg  = r_ex_ctrl.memtoreg;
    assign bus.ex_aluop     = ALUOP_W'(r_ex_ctrl.aluop);
    assign bus.ex_rs1       = r_ex_rs1;
    assign bus.ex_rs2       = r_ex_rs2;
    assign bus.ex_rd        = r_ex_rd;

    assign bus.mem_valid    = r_mem_valid;
    assign bus.mem_memread  = r_mem_memread;
    assign bus.mem_memwrite = r_mem_memwrite;
    assign bus.mem_regwrite = r_mem_regwrite;
    assign bus.mem_memtoreg = r_mem_memtoreg;
    assign bus.mem_rd       = r_mem_rd;

    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_regwrite  = r_wb_regwrite;
    assign bus.wb_memtoreg  = r_wb_memtoreg;
    assign bus.wb_rd        = r_wb_rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed hazard scenarios followed by random
// instruction streams, all checked against an instruction-level pipeline model.
module tb_ctrl_pipeline;

    localparam int K_NOP = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ADDI = 5;

    typedef struct {
        bit       v, rz;
        bit       br, mr, mtr, mw, as, rw;
        bit [1:0] op;
        bit [4:0] rs1, rs2, rd;
    } ins_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ctrl_pipeline_if #(.REG_W(5), .ALUOP_W(2)) bus ();

    ctrl_pipeline #(.REG_W(5), .ALUOP_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    ins_t m_ex, m_mem, m_wb;
    bit   m_known = 1'b0;
    bit   m_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ins_t mk(input int kind, input int rd, input int rs1, input int rs2);
        ins_t t;
        t = '{default: 0};
        t.v   = (kind != K_NOP);
        t.rd  = 5'(rd);
        t.rs1 = 5'(rs1);
        t.rs2 = 5'(rs2);
        case (kind)
            K_R:    begin t.rw = 1; t.op = 2'b10; end
            K_LW:   begin t.mr = 1; t.mtr = 1; t.rw = 1; t.as = 1; end
            K_SW:   begin t.mw = 1; t.as = 1; t.mtr = 1'($urandom_range(0, 1)); end
            K_BEQ:  begin t.br = 1; t.op = 2'b01; t.mtr = 1'($urandom_range(0, 1)); end
            K_ADDI: begin t.as = 1; t.rw = 1; end
            default: begin
                t.br = 1'($urandom_range(0, 1)); t.mr = 1'($urandom_range(0, 1));
                t.rw = 1'($urandom_range(0, 1)); t.op = 2'($urandom_range(0, 3));
            end
        endcase
        return t;
    endfunction

    function automatic ins_t mk_rand();
        int kind;
        kind = ($urandom_range(0, 6) == 0) ? K_NOP : int'($urandom_range(1, 5));
        return mk(kind, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endfunction

    // Forwarding source for a register: newest in-flight writer of a nonzero rd.
    function automatic logic [1:0] exp_fwd(input bit [4:0] rs);
        if (m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.v && m_wb.rw && m_wb.rd != 0 && m_wb.rd == rs)     return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_all(input bit e_flush, input bit e_stall);
        chk("flush",        32'(bus.flush),        32'(e_flush));
        chk("stall",        32'(bus.stall),        32'(e_stall));
        chk("ex_valid",     32'(bus.ex_valid),     32'(m_ex.v));
        chk("ex_branch",    32'(bus.ex_branch),    32'(m_ex.br));
        chk("ex_memread",   32'(bus.ex_memread),   32'(m_ex.mr));
        chk("ex_memwrite",  32'(bus.ex_memwrite),  32'(m_ex.mw));
        chk("ex_alusrc",    32'(bus.ex_alusrc),    32'(m_ex.as));
        chk("ex_regwrite",  32'(bus.ex_regwrite),  32'(m_ex.rw));
        chk("ex_memtoreg",  32'(bus.ex_memtoreg),  32'(m_ex.mtr));
        chk("ex_aluop",     32'(bus.ex_aluop),     32'(m_ex.op));
        if (m_ex.v || m_ex.rz) begin
            chk("ex_rs1",   32'(bus.ex_rs1),       32'(m_ex.rs1));
            chk("ex_rs2",   32'(bus.ex_rs2),       32'(m_ex.rs2));
            chk("ex_rd",    32'(bus.ex_rd),        32'(m_ex.rd));
            chk("fwd_a",    32'(bus.fwd_a),        32'(exp_fwd(m_ex.rs1)));
            chk("fwd_b",    32'(bus.fwd_b),        32'(exp_fwd(m_ex.rs2)));
        end
        chk("mem_valid",    32'(bus.mem_valid),    32'(m_mem.v));
        chk("mem_memread",  32'(bus.mem_memread),  32'(m_mem.mr));
        chk("mem_memwrite", 32'(bus.mem_memwrite), 32'(m_mem.mw));
        chk("mem_regwrite", 32'(bus.mem_regwrite), 32'(m_mem.rw));
        chk("mem_memtoreg", 32'(bus.mem_memtoreg), 32'(m_mem.mtr));
        if (m_mem.v || m_mem.rz)
            chk("mem_rd",   32'(bus.mem_rd),       32'(m_mem.rd));
        chk("wb_valid",     32'(bus.wb_valid),     32'(m_wb.v));
        chk("wb_regwrite",  32'(bus.wb_regwrite),  32'(m_wb.rw));
        chk("wb_memtoreg",  32'(bus.wb_memtoreg),  32'(m_wb.mtr));
        if (m_wb.v || m_wb.rz)
            chk("wb_rd",    32'(bus.wb_rd),        32'(m_wb.rd));
    endtask

    // One cycle: drive at negedge, check just after, then advance the model to the next edge.
    task automatic step(input ins_t id, input bit rst, input bit z);
        bit   e_flush, e_lu;
        ins_t nxt;
        @(negedge clk);
        reset           = rst;
        bus.id_valid    = id.v;
        bus.id_branch   = id.br;
        bus.id_memread  = id.mr;
        bus.id_memtoreg = id.mtr;
        bus.id_memwrite = id.mw;
        bus.id_alusrc   = id.as;
        bus.id_regwrite = id.rw;
        bus.id_aluop    = id.op;
        bus.id_rs1      = id.rs1;
        bus.id_rs2      = id.rs2;
        bus.id_rd       = id.rd;
        bus.ex_zero     = z;
        #1;
        e_flush = m_ex.v && m_ex.br && z;
        e_lu    = m_ex.v && m_ex.mr && m_ex.rd != 0 && id.v &&
                  (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
        m_stall = e_lu && !e_flush;
        if (m_known) check_all(e_flush, m_stall);
        if (rst) begin
            m_ex  = '{default: 0};
            m_ex.rz = 1;
            m_mem = m_ex;
            m_wb  = m_ex;
            m_known = 1'b1;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (e_flush || e_lu || !id.v) begin
                nxt = '{default: 0};
            end else begin
                nxt     = id;
                nxt.mtr = id.mtr && id.rw;
                nxt.rz  = 0;
            end
            m_ex = nxt;
        end
    endtask

    initial begin
        ins_t nop, t, cur;
        bit   r;
        nop = mk(K_NOP, 0, 0, 0);

        // Reset held two cycles with an R-type presented in ID.
        step(mk(K_R, 3, 1, 2), 1, 0);
        step(mk(K_R, 3, 1, 2), 1, 0);
        step(mk(K_R, 3, 1, 2), 0, 0);
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_wb_rd",    32'(bus.wb_rd),    32'd0);
        step(nop, 0, 0);
        chk("first_aluop",    32'(bus.ex_aluop),    32'h2);
        chk("first_regwrite", 32'(bus.ex_regwrite), 32'd1);

        // lw x5 then add x6,x5,x7: one stall cycle, then WB forwarding.
        step(mk(K_LW, 5, 1, 0), 0, 0);
        step(mk(K_R, 6, 5, 7), 0, 0);
        chk("lu_stall", 32'(bus.stall), 32'd1);
        step(mk(K_R, 6, 5, 7), 0, 0);
        chk("lu_bubble",  32'(bus.ex_valid), 32'd0);
        chk("lu_release", 32'(bus.stall),    32'd0);
        step(nop, 0, 0);
        chk("lu_fwd_a", 32'(bus.fwd_a), 32'h1);

        // Back-to-back dependency, then with one nop in between.
        step(mk(K_R, 3, 1, 2), 0, 0);
        step(mk(K_R, 4, 3, 3), 0, 0);
        step(nop, 0, 0);
        chk("b2b_fwd_a", 32'(bus.fwd_a), 32'h2);
        chk("b2b_fwd_b", 32'(bus.fwd_b), 32'h2);
        step(mk(K_R, 3, 1, 2), 0, 0);
        step(nop, 0, 0);
        step(mk(K_R, 4, 3, 3), 0, 0);
        step(nop, 0, 0);
        chk("gap_fwd_a", 32'(bus.fwd_a), 32'h1);
        chk("gap_fwd_b", 32'(bus.fwd_b), 32'h1);

        // Taken and not-taken branch.
        step(mk(K_BEQ, 0, 1, 2), 0, 0);
        step(mk(K_R, 8, 1, 2), 0, 1);
        chk("br_flush", 32'(bus.flush), 32'd1);
        step(nop, 0, 0);
        chk("br_bubble", 32'(bus.ex_valid), 32'd0);
        step(mk(K_BEQ, 0, 1, 2), 0, 0);
        step(mk(K_R, 8, 1, 2), 0, 0);
        chk("nt_flush", 32'(bus.flush), 32'd0);
        step(nop, 0, 0);
        chk("nt_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("nt_ex_rd",    32'(bus.ex_rd),    32'd8);

        // Load-use and taken branch together: flush wins.
        t = mk(K_LW, 5, 1, 0);
        t.br = 1;
        step(t, 0, 0);
        step(mk(K_R, 6, 5, 5), 0, 1);
        chk("both_flush", 32'(bus.flush), 32'd1);
        chk("both_stall", 32'(bus.stall), 32'd0);

        // x0 never stalls or forwards.
        step(mk(K_LW, 0, 1, 0), 0, 0);
        step(mk(K_R, 6, 0, 0), 0, 0);
        chk("x0_stall", 32'(bus.stall), 32'd0);
        step(nop, 0, 0);
        chk("x0_fwd_a", 32'(bus.fwd_a), 32'd0);
        chk("x0_fwd_b", 32'(bus.fwd_b), 32'd0);

        // Reset with all stages occupied.
        step(mk(K_R, 9, 1, 2), 0, 0);
        step(mk(K_SW, 0, 1, 2), 0, 0);
        step(mk(K_R, 10, 1, 2), 0, 0);
        step(mk(K_R, 11, 1, 2), 1, 0);
        step(nop, 0, 0);
        chk("mid_ex_valid",     32'(bus.ex_valid),     32'd0);
        chk("mid_mem_valid",    32'(bus.mem_valid),    32'd0);
        chk("mid_wb_valid",     32'(bus.wb_valid),     32'd0);
        chk("mid_mem_memwrite", 32'(bus.mem_memwrite), 32'd0);
        chk("mid_wb_regwrite",  32'(bus.wb_regwrite),  32'd0);

        // Random stream; ID holds its instruction while stalled, as IF/ID would.
        cur = mk_rand();
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            step(cur, r, 1'($urandom_range(0, 1)));
            if (r || !m_stall) cur = mk_rand();
        end
        step(nop, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Downstream consumer of the main decoder's control bundle (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp).
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage RV32I pipeline.
- Inserts bubbles on load-use hazards and taken-branch flushes.
- Produces EX-stage operand-forwarding selects.

Parameters:
- REG_W, 5, register-index width
- ALUOP_W, 2, ALUOp width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset (one clock; sync active-high fixed)
- id_valid  in  1  ID holds a real instruction
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  decoder outputs
- id_aluop  in  ALUOP_W  decoder ALUOp
- id_rs1, id_rs2, id_rd  in  REG_W each  instruction register fields
- ex_zero  in  1  ALU zero flag for the EX instruction
- stall  out  1  hold PC and IF/ID (combinational)
- flush  out  1  taken branch in EX; kill IF/ID (combinational)
- ex_valid, ex_branch, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite, ex_memtoreg  out  1 each  ID/EX register
- ex_aluop  out  ALUOP_W  ID/EX register
- ex_rs1, ex_rs2, ex_rd  out  REG_W each  ID/EX register
- mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out  1 each  EX/MEM register
- mem_rd  out  REG_W  EX/MEM register
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each  MEM/WB register
- wb_rd  out  REG_W  MEM/WB register
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB

Behaviour:
- Reset (sync): every registered output is 0, including all valid bits, control bits and rd/rs fields. stall, flush and fwd_* follow from the reset state: 0 and 00.
- Bubble: valid=0 with all control bits 0. memtoreg is never X; a decoder X on id_memtoreg is registered as 0 when id_regwrite=0.
- flush = ex_valid & ex_branch & ex_zero.
- load_use = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Both fields are compared regardless of format; false stalls on I-type rs2 are permitted.
- stall = load_use & ~flush. Flush has priority.
- ID/EX at each posedge: bubble if flush | load_use | ~id_valid; otherwise capture the id_* bundle and fields.
- EX/MEM at each posedge: always advances, copying ex_valid/memread/memwrite/regwrite/memtoreg/rd. Never stalled.
- MEM/WB at each posedge: always advances, copying mem_valid/regwrite/memtoreg/rd.
- Latency: decode to EX 1 cycle, to MEM 2, to WB 3.
- Load-use stall is exactly 1 cycle: after the bubble, ex_memread=0 and stall deasserts.
- Branch penalty is 2 instructions: IF/ID is killed externally via flush, and ID/EX is bubbled here.
- fwd_a:
  - 10 if mem_valid & mem_regwrite & mem_rd != 0 & mem_rd == ex_rs1
  - else 01 if wb_valid & wb_regwrite & wb_rd != 0 & wb_rd == ex_rs1
  - else 00
- fwd_b: same rules against ex_rs2. EX/MEM takes priority over MEM/WB (newest value wins).
- x0 never forwards and never stalls.
- Reset asserted mid-operation: all stages become bubbles on that edge; in-flight instructions are discarded.

Decomposition:
- Shared package ctrl_pkg:
  - struct ctrl_bundle_t {branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop}
  - CTRL_BUBBLE constant (all zero)
  - FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01
- One natural sub-module, hazard_fwd_unit: purely combinational, computes stall, flush, fwd_a and fwd_b. Pipeline registers stay in the top level.

Test Plan:
- Reset: drive reset=1 for 2 cycles with id_valid=1 and R-type inputs -> all outputs 0 on release; first R-type appears at ex_* 1 cycle later, ex_aluop=10, ex_regwrite=1.
- Load-use: lw x5 (id_memread=1, rd=5), then add x6,x5,x7 -> stall=1 for exactly 1 cycle; ex_valid=0 the next cycle; add reaches EX the cycle after with fwd_a=01.
- Back-to-back ALU: add x3,x1,x2; sub x4,x3,x3 -> at sub in EX, fwd_a=fwd_b=10. With one nop between -> fwd_a=fwd_b=01.
- Taken branch: beq with ex_zero=1 -> flush=1 for 1 cycle, ID/EX bubbled; not-taken (ex_zero=0) -> flush=0 and the following instruction proceeds.
- Simultaneous events: load in EX with a matching consumer in ID while a taken branch is in EX -> flush=1, stall=0. Also: rd=x0 with lw x0 then a use of x0 -> stall=0, fwd=00.
- Reset mid-stream: assert reset with instructions in all stages -> the next cycle all valid bits and regwrite/memwrite are 0.
